// File: rtl/mult_div_sequencer_pkg.sv
// Shared function codes, FSM encoding and opcode decode for the HI/LO multiply/divide sequencer.
// Build option: MULT_DIV_DIVIDE_EN enables DIV/DIVU decode.
package mult_div_sequencer_pkg;

   localparam logic [5:0] FUNC_MULT  = 6'b011000;
   localparam logic [5:0] FUNC_MULTU = 6'b011001;
   localparam logic [5:0] FUNC_DIV   = 6'b011010;
   localparam logic [5:0] FUNC_DIVU  = 6'b011011;

`ifdef MULT_DIV_DIVIDE_EN
   localparam logic DIV_EN = 1'b1;
`else
   localparam logic DIV_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic valid;
      logic is_signed;
      logic is_div;
   } op_dec_t;

   // Divide codes decode as invalid when the divider is not built.
   function automatic op_dec_t decode_func(input logic [5:0] func);
      op_dec_t d;
      d = '0;
      case (func)
         FUNC_MULT:  d = '{valid: 1'b1,   is_signed: 1'b1, is_div: 1'b0};
         FUNC_MULTU: d = '{valid: 1'b1,   is_signed: 1'b0, is_div: 1'b0};
         FUNC_DIV:   d = '{valid: DIV_EN, is_signed: 1'b1, is_div: 1'b1};
         FUNC_DIVU:  d = '{valid: DIV_EN, is_signed: 1'b0, is_div: 1'b1};
         default:    d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/mult_div_sequencer_if.sv
// EX-stage request/response bundle between the pipeline and the multiply/divide sequencer.
interface mult_div_sequencer_if #(parameter int unsigned WIDTH = 32);
   logic             start;
   logic [5:0]       function_field;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             mf_req;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;
   logic             stall;

   modport master (
      output start, function_field, operand_a, operand_b, mf_req,
      input  hi, lo, busy, done, stall
   );

   modport slave (
      input  start, function_field, operand_a, operand_b, mf_req,
      output hi, lo, busy, done, stall
   );
endinterface

// File: rtl/mult_div_sequencer_shift_core.sv
// Radix-2 shift-add multiplier / restoring divider on unsigned magnitudes, one bit per step.
// Build option: MULT_DIV_DIVIDE_EN builds the divide path; otherwise op_is_div is ignored.
module mult_div_sequencer_shift_core #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic             op_is_div,
   input  logic [WIDTH-1:0] a_mag,
   input  logic [WIDTH-1:0] b_mag,
   output logic [WIDTH-1:0] raw_hi_c,
   output logic [WIDTH-1:0] raw_lo_c
);

   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] operand;
   logic [WIDTH:0]   sum_c;

   assign sum_c = {1'b0, acc} + (shreg[0] ? {1'b0, operand} : '0);

`ifdef MULT_DIV_DIVIDE_EN
   logic [WIDTH:0] shifted_c;
   logic           take_c;

   // A zero divisor always subtracts, yielding all-ones quotient and remainder = dividend.
   assign shifted_c = {acc, shreg[WIDTH-1]};
   assign take_c    = (shifted_c >= {1'b0, operand});

   always_comb begin
      raw_hi_c = sum_c[WIDTH:1];
      raw_lo_c = {sum_c[0], shreg[WIDTH-1:1]};
      if (op_is_div) begin
         raw_hi_c = take_c ? (shifted_c[WIDTH-1:0] - operand) : shifted_c[WIDTH-1:0];
         raw_lo_c = {shreg[WIDTH-2:0], take_c};
      end
   end
`else
   logic unused_div;
   assign unused_div = op_is_div;

   always_comb begin
      raw_hi_c = sum_c[WIDTH:1];
      raw_lo_c = {sum_c[0], shreg[WIDTH-1:1]};
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         shreg   <= '0;
         operand <= '0;
      end else if (load) begin
         acc     <= '0;
         shreg   <= a_mag;
         operand <= b_mag;
      end else if (step) begin
         acc     <= raw_hi_c;
         shreg   <= raw_lo_c;
      end
   end

endmodule

// File: rtl/mult_div_sequencer.sv
// MULT/MULTU (and DIV/DIVU with MULT_DIV_DIVIDE_EN) sequencer owning HI/LO and raising pipeline stalls.
module mult_div_sequencer
   import mult_div_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input logic              clk,
   input logic              rst_n,
   mult_div_sequencer_if.slave bus
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam int unsigned PW = 2 * WIDTH;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state, state_next;
   logic [CW-1:0]    count;
   op_dec_t          dec_c;
   logic             accept_c, finish_c;
   logic             neg_a_c, neg_b_c;
   logic [WIDTH-1:0] a_mag_c, b_mag_c;
   logic             op_div, sign_a, sign_b, b_zero;
   logic             busy_q, done_q, busy_next, done_next;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic [WIDTH-1:0] raw_hi_c, raw_lo_c, hi_fix_c, lo_fix_c;
   logic [PW-1:0]    prod, prod_neg;

   assign dec_c    = decode_func(bus.function_field);
   assign accept_c = bus.start & dec_c.valid & (state != ST_CALC);
   assign finish_c = (state == ST_CALC) && (count == LAST);

   assign neg_a_c = dec_c.is_signed & bus.operand_a[WIDTH-1];
   assign neg_b_c = dec_c.is_signed & bus.operand_b[WIDTH-1];
   assign a_mag_c = neg_a_c ? (~bus.operand_a + WIDTH'(1)) : bus.operand_a;
   assign b_mag_c = neg_b_c ? (~bus.operand_b + WIDTH'(1)) : bus.operand_b;

   mult_div_sequencer_shift_core #(.WIDTH(WIDTH)) u_core (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept_c),
      .step      (state == ST_CALC),
      .op_is_div (op_div),
      .a_mag     (a_mag_c),
      .b_mag     (b_mag_c),
      .raw_hi_c  (raw_hi_c),
      .raw_lo_c  (raw_lo_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (accept_c) state_next = ST_CALC;
         ST_CALC: if (count == LAST) state_next = ST_DONE;
         ST_DONE: state_next = accept_c ? ST_CALC : ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy_next = 1'b0;
      done_next = 1'b0;
      if (state_next == ST_CALC) busy_next = 1'b1;
      if (state_next == ST_DONE) done_next = 1'b1;
   end

   // Sign fix-up on the post-final-step raw result; a zero divisor keeps the all-ones quotient.
   always_comb begin
      prod     = {raw_hi_c, raw_lo_c};
      prod_neg = ~prod + PW'(1);
      hi_fix_c = raw_hi_c;
      lo_fix_c = raw_lo_c;
      if (op_div) begin
         if (sign_a) hi_fix_c = ~raw_hi_c + WIDTH'(1);
         if ((sign_a ^ sign_b) && !b_zero) lo_fix_c = ~raw_lo_c + WIDTH'(1);
      end else if (sign_a ^ sign_b) begin
         {hi_fix_c, lo_fix_c} = prod_neg;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count  <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         op_div <= 1'b0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         b_zero <= 1'b0;
      end else begin
         busy_q <= busy_next;
         done_q <= done_next;
         if (accept_c) begin
            count  <= '0;
            op_div <= dec_c.is_div;
            sign_a <= neg_a_c;
            sign_b <= neg_b_c;
            b_zero <= (bus.operand_b == '0);
         end else if (state == ST_CALC) begin
            count <= count + CW'(1);
         end
         if (finish_c) begin
            hi_q <= hi_fix_c;
            lo_q <= lo_fix_c;
         end
      end
   end

   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.stall = busy_q & (bus.start | bus.mf_req);

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Self-checking bench for mult_div_sequencer: directed cases plus randomized back-to-back ops vs. an arithmetic model.
module tb_mult_div_sequencer;
   import mult_div_sequencer_pkg::*;

   localparam int unsigned WIDTH = 32;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   mult_div_sequencer_if #(.WIDTH(WIDTH)) bus ();

   mult_div_sequencer #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Reference result {hi, lo} from plain 64-bit arithmetic.
   function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, p, q, r;
      logic [63:0] res;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      res = '0;
      case (f)
         FUNC_MULT: begin
            p   = sa * sb;
            res = p;
         end
         FUNC_MULTU: res = {32'b0, a} * {32'b0, b};
         FUNC_DIV: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else begin
               q   = sa / sb;
               r   = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         FUNC_DIVU: begin
            if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
            else            res = {a % b, a / b};
         end
         default: res = '0;
      endcase
      return res;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      bus.start          = 1'b1;
      bus.function_field = f;
      bus.operand_a      = a;
      bus.operand_b      = b;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (bus.done !== 1'b1 && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] corner_vals [5];
      corner_vals = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      if ($urandom_range(0, 3) == 0) return corner_vals[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   task automatic test_reset();
      rst_n              = 1'b0;
      bus.start          = 1'b0;
      bus.function_field = 6'd0;
      bus.operand_a      = '0;
      bus.operand_b      = '0;
      bus.mf_req         = 1'b0;
      #3;
      checks++; if (bus.hi !== 32'd0)  begin errors++; $display("FAIL reset_hi: got %h expected 0", bus.hi); end
      checks++; if (bus.lo !== 32'd0)  begin errors++; $display("FAIL reset_lo: got %h expected 0", bus.lo); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall); end
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_multu_max();
      int lat;
      issue(FUNC_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL multu_busy: got %b expected 1", bus.busy); end
      wait_done(lat);
      checks++; if (lat != 32) begin errors++; $display("FAIL multu_latency: got %0d expected 32", lat); end
      checks++; if (bus.hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h expected fffffffe", bus.hi); end
      checks++; if (bus.lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h expected 00000001", bus.lo); end
      tick();
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b expected 0", bus.done); end
   endtask

   task automatic test_mult_neg();
      int lat;
      issue(FUNC_MULT, 32'hFFFF_FFFD, 32'd7);
      wait_done(lat);
      checks++; if (lat != 32) begin errors++; $display("FAIL mult_latency: got %0d expected 32", lat); end
      checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h expected ffffffff", bus.hi); end
      checks++; if (bus.lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo: got %h expected ffffffeb", bus.lo); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mult_busy_after: got %b expected 0", bus.busy); end
      tick();
   endtask

   task automatic test_stall();
      int n, lat;
      issue(FUNC_MULTU, 32'h10, 32'h20);
      repeat (4) tick();
      bus.start          = 1'b1;
      bus.function_field = FUNC_MULT;
      bus.operand_a      = 32'hFFFF_FFFD;
      bus.operand_b      = 32'd7;
      bus.mf_req         = 1'b1;
      #1;
      n = 0;
      while (bus.done !== 1'b1 && n < 100) begin
         checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL stall_in_calc: got %b expected 1 at cycle %0d", bus.stall, n); end
         tick();
         n++;
      end
      checks++; if (n != 28) begin errors++; $display("FAIL stall_first_latency: got %0d expected 28", n); end
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL stall_in_done: got %b expected 0", bus.stall); end
      checks++; if (bus.lo !== 32'h200) begin errors++; $display("FAIL stall_first_lo: got %h expected 00000200", bus.lo); end
      checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL stall_first_hi: got %h expected 0", bus.hi); end
      tick();
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL stall_reissue_busy: got %b expected 1", bus.busy); end
      bus.start  = 1'b0;
      bus.mf_req = 1'b0;
      wait_done(lat);
      checks++; if (lat != 32) begin errors++; $display("FAIL stall_second_latency: got %0d expected 32", lat); end
      checks++; if (bus.lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL stall_second_lo: got %h expected ffffffeb", bus.lo); end
      checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL stall_second_hi: got %h expected ffffffff", bus.hi); end
      tick();
   endtask

   task automatic test_reset_mid();
      int lat, seen;
      issue(FUNC_MULTU, 32'hDEAD_BEEF, 32'h1234_5678);
      repeat (9) tick();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL rstmid_hi: got %h expected 0", bus.hi); end
      checks++; if (bus.lo !== 32'd0) begin errors++; $display("FAIL rstmid_lo: got %h expected 0", bus.lo); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
      tick();
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
         tick();
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d active cycles expected 0", seen); end
      issue(FUNC_MULTU, 32'd3, 32'd4);
      wait_done(lat);
      checks++; if (lat != 32) begin errors++; $display("FAIL rstmid_latency: got %0d expected 32", lat); end
      checks++; if (bus.lo !== 32'd12) begin errors++; $display("FAIL rstmid_lo_after: got %h expected 0000000c", bus.lo); end
      checks++; if (bus.hi !== 32'd0) begin errors++; $display("FAIL rstmid_hi_after: got %h expected 0", bus.hi); end
      tick();
   endtask

   task automatic test_divide();
      int lat;
`ifdef MULT_DIV_DIVIDE_EN
      issue(FUNC_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done(lat);
      checks++; if (lat != 32) begin errors++; $display("FAIL div_latency: got %0d expected 32", lat); end
      checks++; if (bus.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h expected fffffffd", bus.lo); end
      checks++; if (bus.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h expected ffffffff", bus.hi); end
      issue(FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(lat);
      checks++; if (bus.lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo: got %h expected 80000000", bus.lo); end
      checks++; if (bus.hi !== 32'h0) begin errors++; $display("FAIL div_ovf_hi: got %h expected 0", bus.hi); end
      tick();
`else
      logic [31:0] hi0, lo0;
      hi0 = bus.hi;
      lo0 = bus.lo;
      issue(FUNC_DIV, 32'hFFFF_FFF9, 32'd2);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL div_off_busy: got %b expected 0", bus.busy); end
      wait_done(lat);
      checks++; if (lat != 100) begin errors++; $display("FAIL div_off_done: got done after %0d cycles expected none", lat); end
      checks++; if (bus.hi !== hi0) begin errors++; $display("FAIL div_off_hi: got %h expected %h", bus.hi, hi0); end
      checks++; if (bus.lo !== lo0) begin errors++; $display("FAIL div_off_lo: got %h expected %h", bus.lo, lo0); end
`endif
   endtask

   task automatic test_div_zero();
      int lat;
`ifdef MULT_DIV_DIVIDE_EN
      issue(FUNC_DIVU, 32'h1234, 32'd0);
      wait_done(lat);
      checks++; if (lat != 32) begin errors++; $display("FAIL div0_latency: got %0d expected 32", lat); end
      checks++; if (bus.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo: got %h expected ffffffff", bus.lo); end
      checks++; if (bus.hi !== 32'h0000_1234) begin errors++; $display("FAIL div0_hi: got %h expected 00001234", bus.hi); end
      tick();
`else
      logic [31:0] hi0, lo0;
      hi0 = bus.hi;
      lo0 = bus.lo;
      issue(FUNC_DIVU, 32'h1234, 32'd0);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL divu_off_busy: got %b expected 0", bus.busy); end
      repeat (3) tick();
      checks++; if (bus.hi !== hi0 || bus.lo !== lo0) begin errors++; $display("FAIL divu_off_hilo: got %h/%h expected %h/%h", bus.hi, bus.lo, hi0, lo0); end
`endif
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [5:0]  f;
      logic [31:0] a, b;
      logic [63:0] exp;
`ifdef MULT_DIV_DIVIDE_EN
      logic [5:0] funcs [4];
      funcs = '{FUNC_MULT, FUNC_MULTU, FUNC_DIV, FUNC_DIVU};
`else
      logic [5:0] funcs [2];
      funcs = '{FUNC_MULT, FUNC_MULTU};
`endif
      for (int i = 0; i < 24; i++) begin
         f   = funcs[$urandom_range(0, $size(funcs) - 1)];
         a   = pick_operand();
         b   = pick_operand();
         exp = model(f, a, b);
         issue(f, a, b);
         wait_done(lat);
         checks++; if (lat != 32) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d expected 32", i, lat); end
         checks++; if (bus.hi !== exp[63:32]) begin errors++; $display("FAIL b2b_hi[%0d] f=%b a=%h b=%h: got %h expected %h", i, f, a, b, bus.hi, exp[63:32]); end
         checks++; if (bus.lo !== exp[31:0]) begin errors++; $display("FAIL b2b_lo[%0d] f=%b a=%h b=%h: got %h expected %h", i, f, a, b, bus.lo, exp[31:0]); end
      end
      tick();
   endtask

   task automatic test_invalid();
      logic [5:0]  f;
      logic [31:0] hi0, lo0;
      for (int i = 0; i < 6; i++) begin
         f = 6'($urandom_range(0, 63));
         if (f == FUNC_MULT || f == FUNC_MULTU || f == FUNC_DIV || f == FUNC_DIVU) f = 6'b100000;
         hi0 = bus.hi;
         lo0 = bus.lo;
         issue(f, $urandom, $urandom);
         checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL invalid_busy[%0d] f=%b: got %b expected 0", i, f, bus.busy); end
         tick();
         checks++; if (bus.hi !== hi0 || bus.lo !== lo0) begin errors++; $display("FAIL invalid_hilo[%0d]: got %h/%h expected %h/%h", i, bus.hi, bus.lo, hi0, lo0); end
      end
   endtask

   initial begin
      test_reset();
      test_multu_max();
      test_mult_neg();
      test_stall();
      test_reset_mid();
      test_divide();
      test_div_zero();
      test_back_to_back();
      test_invalid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
